// File: rtl/btn_pkg.sv
// Shared sizing helpers for the push-button event front end.
package btn_pkg;

    // Width of a button index; never narrower than one bit.
    function automatic int code_width(input int n_btn);
        return (n_btn > 1) ? $clog2(n_btn) : 1;
    endfunction

    // Width of the debounce counter so that it can hold DEB_MAX.
    function automatic int count_width(input int deb_max);
        return $clog2(deb_max + 1);
    endfunction

    // FIFO pointer width: index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: 2-flop synchroniser, saturating qualify counter and
// a single-cycle press pulse per continuous high period.
module btn_debounce_cell
    import btn_pkg::*;
#(
    parameter int DEB_MAX = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = count_width(DEB_MAX);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_MAX);

    logic [1:0]    sync;
    logic          s;
    logic [CW-1:0] cnt;
    logic          fired;

    assign s = sync[1];

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], btn_raw};
        end
    end

    // Count consecutive high samples; fire once when the count is reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            fired <= 1'b0;
            press <= 1'b0;
        end else if (!s) begin
            cnt   <= '0;
            fired <= 1'b0;
            press <= 1'b0;
        end else begin
            if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if ((cnt == CNT_MAX) && !fired) begin
                press <= 1'b1;
                fired <= 1'b1;
            end else begin
                press <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// Button front end: debounced presses become pending requests, a
// round-robin arbiter serialises them into an index FIFO drained by
// a valid/ready consumer.
module btn_event_arbiter
    import btn_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int DEB_MAX    = 100,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_BTN-1:0]              btn_raw,
    output logic                          evt_valid,
    output logic [code_width(N_BTN)-1:0]  evt_code,
    input  logic                          evt_ready,
    output logic                          drop_flag,
    input  logic                          clear_flags,
    output logic [N_BTN-1:0]              pending
);

    localparam int CODE_W = code_width(N_BTN);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PW     = ptr_width(FIFO_DEPTH);
    localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(N_BTN - 1);

    logic [N_BTN-1:0]  press;
    logic [CODE_W-1:0] rr_ptr;
    logic [CODE_W-1:0] cand;
    logic [CODE_W-1:0] grant_idx;
    logic              grant_valid;
    logic [N_BTN-1:0]  grant_oh;
    logic              drop_now;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic              full;
    logic              empty;
    logic              pop;
    logic              can_push;

    for (genvar i = 0; i < N_BTN; i++) begin : g_cell
        btn_debounce_cell #(
            .DEB_MAX (DEB_MAX)
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .btn_raw (btn_raw[i]),
            .press   (press[i])
        );
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign evt_valid = !empty;
    assign evt_code  = mem[rd_ptr[AW-1:0]];
    assign pop       = evt_valid && evt_ready;
    assign can_push  = !full || pop;
    assign drop_now  = |(press & pending & ~grant_oh);

    // Round-robin pick: first pending index at or above rr_ptr, wrapping.
    always_comb begin
        cand        = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        grant_oh    = '0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            cand = CODE_W'((32'(rr_ptr) + k) % int'(N_BTN));
            if (!grant_valid && can_push && pending[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_valid) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Pending bits (set beats grant-clear), round-robin pointer and drop flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= '0;
            rr_ptr    <= '0;
            drop_flag <= 1'b0;
        end else begin
            pending <= press | (pending & ~grant_oh);
            if (grant_valid) begin
                rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end
            if (drop_now) begin
                drop_flag <= 1'b1;
            end else if (clear_flags) begin
                drop_flag <= 1'b0;
            end
        end
    end

    // Event FIFO: granted index is pushed, consumer handshake pops the head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (grant_valid) begin
                mem[wr_ptr[AW-1:0]] <= grant_idx;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Front-end input controller for the board push-buttons. It debounces N raw button lines and latches each accepted press as a pending request. A round-robin arbiter serialises the requests into a small FIFO of button indices, and the game/control FSM drains that FIFO through a valid/ready handshake. Simultaneous presses are never lost unless a button is pressed again while its earlier press is still pending.

## Interface
- `N_BTN`, 4: number of button inputs (2..8).
- `DEB_MAX`, 100: number of consecutive high samples required to accept a press (≥1).
- `FIFO_DEPTH`, 4: event FIFO entries (power of two, ≥2).
- `clk` input 1: single system clock.
- `reset` input 1: asynchronous, active-low reset.
- `btn_raw` input N_BTN: raw, asynchronous button levels (1 = pressed).
- `evt_valid` output 1: FIFO non-empty.
- `evt_code` output $clog2(N_BTN): button index at the FIFO head.
- `evt_ready` input 1: consumer accepts the head entry when `evt_valid` is also high.
- `drop_flag` output 1: sticky; a press was merged into an already-pending request.
- `clear_flags` input 1: synchronous clear of `drop_flag`.
- `pending` output N_BTN: current pending request bits (debug/status).

## Operation
- **Synchroniser:** each `btn_raw` bit passes through a 2-flop synchroniser; `s[i]` is the second-stage output.
- **Debounce cell, per button:** counter `cnt` of width $clog2(DEB_MAX+1) and a `fired` bit.
  - `s[i]`=0: `cnt`←0 and `fired`←0.
  - `s[i]`=1 and `cnt`<DEB_MAX: `cnt`←`cnt`+1.
  - `s[i]`=1, `cnt`==DEB_MAX and `fired`=0: `press[i]`←1 for one cycle and `fired`←1. `cnt` saturates at DEB_MAX.
  - Result: exactly one press per continuous high period.
- **Pending bits:**
  - `press[i]` sets `pending[i]`.
  - A grant of button i clears `pending[i]`.
  - Press and grant on the same button in the same cycle: set wins, and `pending[i]` stays 1.
  - Press while `pending[i]`=1 and no grant of i in that cycle: `drop_flag`←1.
- **Arbiter (combinational grant, registered effects):**
  - A grant is issued when any pending bit is set and the FIFO is not full, or is full with a pop in the same cycle.
  - Grant goes to the first pending index at or after `rr_ptr`, scanning upward with wrap-around.
  - On a grant, the index is written into the FIFO and `rr_ptr`←(grant+1) mod N_BTN.
  - No grant: `rr_ptr` holds.
- **FIFO:**
  - Read and write pointers are $clog2(FIFO_DEPTH)+1 bits; full and empty are decoded from the MSB.
  - Push and pop in the same cycle are legal when full (net count unchanged) and when empty only if a push precedes, i.e. no pop while empty.
  - `evt_code` is driven combinationally from the head entry.
- **`drop_flag`:** `clear_flags` and a new drop in the same cycle leaves `drop_flag`=1.

## Timing
- **Reset values:** `evt_valid`=0, `evt_code`=0, `drop_flag`=0, `pending`=0. Internally, `rr_ptr`=0, all `cnt`/`fired` bits, synchroniser flops and FIFO pointers are 0.
- **Press latency:** `btn_raw[i]` is first sampled high at edge E0 and stays high.
  - `s[i]`=1 after E1.
  - `cnt` reaches DEB_MAX after E(DEB_MAX+1).
  - `press` is high after E(DEB_MAX+2).
  - `pending` is set after E(DEB_MAX+3).
  - FIFO write occurs, so `evt_valid`=1, after E(DEB_MAX+4), given an uncontended, non-full FIFO.
- **Glitches:** a high pulse shorter than DEB_MAX+1 synchronised samples produces no event.
- **Throughput:** one grant per cycle maximum, one pop per cycle maximum.
- **Asynchronous reset mid-operation:** all state clears immediately. After release, a button still held must be re-qualified from `cnt`=0, so a held button produces a new event.

## Structure
- **Shared package `btn_pkg`:**
  - localparam functions for code width and counter width.
  - An `evt_t` typedef, if the consumer FSM also imports it.
- **Sub-module `btn_debounce_cell`:** synchroniser, counter, `fired` and `press` output, instanced N_BTN times.
- **Top level:** arbiter, pending register, FIFO and flags.

## Test plan
All scenarios use N_BTN=4, DEB_MAX=3, FIFO_DEPTH=4.
- **Reset values:** reset low mid-count → outputs read 0 immediately; holding btn1 through the release → event code 1 appears 7 edges after release.
- **Single press:** btn2 high for 20 cycles, `evt_ready`=1 → exactly one `evt_valid` pulse with `evt_code`=2, asserted after E7. A 3-cycle glitch on btn2 → no event.
- **Simultaneous press:** btn0..3 rise in the same cycle, `evt_ready`=0 → FIFO receives codes 0,1,2,3 on consecutive cycles and `rr_ptr` ends at 0. Draining then yields 0,1,2,3.
- **Round-robin fairness:** after a grant of btn1, btn0 and btn3 become pending together → btn3 is granted before btn0.
- **Full FIFO and drop:** FIFO holds 4 entries, `evt_ready`=0, btn0 pending. A second btn0 press → `drop_flag`=1. Set `evt_ready`=1 → btn0 pushes in the same cycle as the pop. Pulse `clear_flags` → `drop_flag`=0.
- **Set-wins collision:** a btn2 press lands in the same cycle btn2 is granted → `pending[2]` stays 1, two code-2 events are delivered, and `drop_flag` stays 0.
